// File: rtl/seg_display_mmio.sv
// Memory-mapped multi-group 7-segment scanner with leading-zero blanking, PWM brightness and readback.
// Optional digit blinking (BLINK register on addr 3) is built when SEG_BLINK_EN is defined.
module seg_display_mmio #(
  parameter int NUM_GROUPS       = 2,
  parameter int DIGITS_PER_GROUP = 4,
  parameter int SCAN_DIV         = 200000,
  parameter int BLINK_DIV        = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   we,
  input  logic [1:0]                             addr,
  input  logic [31:0]                            din,
  output logic [31:0]                            rd,
  output logic [8*NUM_GROUPS-1:0]                seg_out,
  output logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0] seg_sel,
  output logic [7:0]                             aux_seg,
  output logic                                   aux_sel
);

  localparam int TOTAL = NUM_GROUPS * DIGITS_PER_GROUP;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS_PER_GROUP > 1) ? $clog2(DIGITS_PER_GROUP) : 1;

  if ((TOTAL > 8) || (SCAN_DIV < 2) || (BLINK_DIV < 1)) begin : gIllegalParams
    $error("seg_display_mmio: illegal parameter combination");
  end

  function automatic logic [7:0] hexSeg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

  logic [31:0]      data_q, data_d;
  logic [3:0]       sign_q, sign_d;
  logic             en_q, en_d;
  logic             lzb_q, lzb_d;
  logic [3:0]       bright_q, bright_d;
  logic [CNT_W-1:0] scanCnt_q, scanCnt_d;
  logic [IDX_W-1:0] scanIdx_q, scanIdx_d;
  logic [3:0]       pwmCnt_q, pwmCnt_d;
  logic             scanTc;
  logic             lastIdx;
  logic             lit;
  logic             dispOn;
  logic [TOTAL-1:0] blinkHide;
  logic [TOTAL-1:0] hideDigit;
  logic [7:0]       digitPat [NUM_GROUPS][DIGITS_PER_GROUP];

  // Register file updates; a write lands at the edge, so rd shows the old value that cycle.
  always_comb begin
    data_d   = data_q;
    sign_d   = sign_q;
    en_d     = en_q;
    lzb_d    = lzb_q;
    bright_d = bright_q;
    if (we) begin
      case (addr)
        2'd0: data_d = din;
        2'd1: sign_d = din[3:0];
        2'd2: begin
          en_d     = din[0];
          lzb_d    = din[1];
          bright_d = din[7:4];
        end
        default: ;
      endcase
    end
  end

  // Scan and PWM run freely and never depend on bus activity.
  assign scanTc  = (scanCnt_q == CNT_W'(SCAN_DIV - 1));
  assign lastIdx = (scanIdx_q == IDX_W'(DIGITS_PER_GROUP - 1));

  always_comb begin
    scanCnt_d = scanCnt_q + 1'b1;
    scanIdx_d = scanIdx_q;
    pwmCnt_d  = pwmCnt_q + 4'd1;
    if (scanTc) begin
      scanCnt_d = '0;
      scanIdx_d = lastIdx ? '0 : scanIdx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      sign_q    <= '0;
      en_q      <= 1'b1;
      lzb_q     <= 1'b0;
      bright_q  <= 4'hF;
      scanCnt_q <= '0;
      scanIdx_q <= '0;
      pwmCnt_q  <= '0;
    end else begin
      data_q    <= data_d;
      sign_q    <= sign_d;
      en_q      <= en_d;
      lzb_q     <= lzb_d;
      bright_q  <= bright_d;
      scanCnt_q <= scanCnt_d;
      scanIdx_q <= scanIdx_d;
      pwmCnt_q  <= pwmCnt_d;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [TOTAL-1:0] blinkMask_q, blinkMask_d;
  logic [BW-1:0]    blinkCnt_q, blinkCnt_d;
  logic             blinkOff_q, blinkOff_d;
  logic             frameEnd;

  assign frameEnd = scanTc && lastIdx;

  // Phase flips after every BLINK_DIV completed frames.
  always_comb begin
    blinkMask_d = blinkMask_q;
    blinkCnt_d  = blinkCnt_q;
    blinkOff_d  = blinkOff_q;
    if (we && (addr == 2'd3)) begin
      blinkMask_d = din[TOTAL-1:0];
    end
    if (frameEnd) begin
      if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
        blinkCnt_d = '0;
        blinkOff_d = ~blinkOff_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blinkMask_q <= '0;
      blinkCnt_q  <= '0;
      blinkOff_q  <= 1'b0;
    end else begin
      blinkMask_q <= blinkMask_d;
      blinkCnt_q  <= blinkCnt_d;
      blinkOff_q  <= blinkOff_d;
    end
  end

  assign blinkHide = blinkOff_q ? blinkMask_q : '0;

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd = data_q;
      2'd1: rd[3:0] = sign_q;
      2'd2: rd[7:0] = {bright_q, 2'b00, lzb_q, en_q};
      default: rd[TOTAL-1:0] = blinkMask_q;
    endcase
  end
`else
  assign blinkHide = '0;

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd = data_q;
      2'd1: rd[3:0] = sign_q;
      2'd2: rd[7:0] = {bright_q, 2'b00, lzb_q, en_q};
      default: rd[IDX_W-1:0] = scanIdx_q;
    endcase
  end
`endif

  assign lit    = (bright_q == 4'hF) || (pwmCnt_q < bright_q);
  assign dispOn = en_q && lit;

  // A digit is a leading zero when it and every higher displayed nibble are zero; digit 0 always shows.
  assign hideDigit[0] = blinkHide[0];
  for (genvar i = 1; i < TOTAL; i++) begin : gHide
    assign hideDigit[i] = blinkHide[i] || (lzb_q && (data_q[4*TOTAL-1:4*i] == '0));
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : gGroup
    for (genvar l = 0; l < DIGITS_PER_GROUP; l++) begin : gLocal
      assign digitPat[g][l] = hideDigit[g*DIGITS_PER_GROUP+l] ? 8'hFF
                            : hexSeg(data_q[4*(g*DIGITS_PER_GROUP+l) +: 4]);
    end
    assign seg_out[8*g +: 8] = dispOn ? digitPat[g][scanIdx_q] : 8'hFF;
    assign seg_sel[g*DIGITS_PER_GROUP +: DIGITS_PER_GROUP] =
      dispOn ? (DIGITS_PER_GROUP'(1) << scanIdx_q) : '0;
  end

  assign aux_seg = dispOn ? hexSeg(sign_q) : 8'hFF;
  assign aux_sel = dispOn;

endmodule
